// File: rtl/pkt_value_unpacker_pkg.sv
// Shared definitions for the packet value unpacker.
// Holds the FSM state type, metadata field offsets, summary field offsets and
// the helper that turns a byte length into an expected value count.
package pkt_value_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERIALIZE = 2'd1,
    SUMMARY   = 2'd2
  } state_t;

  localparam int unsigned SESSION_W = 16;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned COUNT_W   = 16;

  // Metadata field offsets.
  localparam int unsigned META_SESSION_LSB = 0;
  localparam int unsigned META_LEN_LSB     = 16;

  // Summary word layout: {mismatch, value_count, session}.
  localparam int unsigned SUM_SESSION_LSB  = 0;
  localparam int unsigned SUM_COUNT_LSB    = 16;
  localparam int unsigned SUM_MISMATCH_BIT = 32;
  localparam int unsigned SUM_W            = 33;

  // Byte length to number of 32-bit values.
  function automatic logic [COUNT_W-1:0] len_to_values(input logic [LEN_W-1:0] len_bytes);
    return len_bytes >> 2;
  endfunction

endpackage

// File: rtl/pkt_value_unpacker_value_reg_slice.sv
// Optional output register slice for the value stream.
// ENABLE=0: pure wiring. ENABLE=1: one forward register stage with full
// throughput (in_ready is high whenever the stage is empty or draining).
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream.
module value_reg_slice #(
  parameter int unsigned W      = 49,
  parameter bit          ENABLE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (ENABLE) begin : g_reg
    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (in_ready) begin
        valid_q <= in_valid;
        if (in_valid) data_q <= in_data;
      end
    end
  end else begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end

endmodule

// File: rtl/pkt_value_unpacker.sv
// Packet value unpacker.
// Accepts wide payload beats ({metadata, tlast, tdata}) and serialises each
// beat into DATA_W/VALUE_W values, lane 0 first. After the last beat of a
// packet a summary {mismatch, value_count, session} is emitted.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pkt_rx_TDATA/TVALID/TREADY          input beat stream
//   m_axis_value_TDATA/TUSER/TLAST/TVALID/TREADY   value stream (TUSER=session)
//   m_axis_summary_TDATA/TVALID/TREADY  per-packet summary
module pkt_value_unpacker
  import pkt_value_unpacker_pkg::*;
#(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned META_W  = 88,
  parameter int unsigned VALUE_W = 32,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [META_W+DATA_W:0]    pkt_rx_TDATA,
  input  logic                      pkt_rx_TVALID,
  output logic                      pkt_rx_TREADY,
  output logic [VALUE_W-1:0]        m_axis_value_TDATA,
  output logic [SESSION_W-1:0]      m_axis_value_TUSER,
  output logic                      m_axis_value_TVALID,
  output logic                      m_axis_value_TLAST,
  input  logic                      m_axis_value_TREADY,
  output logic [SUM_W-1:0]          m_axis_summary_TDATA,
  output logic                      m_axis_summary_TVALID,
  input  logic                      m_axis_summary_TREADY
);

  localparam int unsigned LANES   = DATA_W / VALUE_W;
  localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam int unsigned SLICE_W = VALUE_W + SESSION_W + 1;

  state_t state, state_nxt;

  logic [META_W-1:0]   rx_meta;
  logic                rx_last;
  logic [DATA_W-1:0]   rx_data;
  logic                unused_meta;

  logic [DATA_W-1:0]   data_r;
  logic                last_r;
  logic [SESSION_W-1:0] session_r;
  logic [LEN_W-1:0]    len_r;
  logic                in_pkt;
  logic [LANE_W-1:0]   lane;
  logic [COUNT_W-1:0]  value_count;

  logic                val_valid;
  logic                val_ready;
  logic                rx_hs;
  logic                val_hs;
  logic                sum_hs;
  logic                at_last_lane;

  logic [VALUE_W-1:0]  lane_data [LANES];
  logic [SLICE_W-1:0]  slice_in;
  logic [SLICE_W-1:0]  slice_out;

  assign {rx_meta, rx_last, rx_data} = pkt_rx_TDATA;
  assign unused_meta = ^rx_meta[META_W-1:META_LEN_LSB+LEN_W];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_data[i] = data_r[i*VALUE_W +: VALUE_W];
  end

  assign at_last_lane = (lane == LAST_LANE);
  assign rx_hs  = pkt_rx_TVALID && pkt_rx_TREADY;
  assign val_hs = val_valid && val_ready;
  assign sum_hs = m_axis_summary_TVALID && m_axis_summary_TREADY;

  // in_pkt marks that session/length of the current packet are already
  // latched, so later beats (possibly arriving via IDLE) keep the first ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_r      <= '0;
      last_r      <= 1'b0;
      session_r   <= '0;
      len_r       <= '0;
      in_pkt      <= 1'b0;
      lane        <= '0;
      value_count <= '0;
    end else begin
      state <= state_nxt;
      if (rx_hs) begin
        data_r <= rx_data;
        last_r <= rx_last;
        lane   <= '0;
        in_pkt <= 1'b1;
        if (!in_pkt) begin
          session_r <= rx_meta[META_SESSION_LSB +: SESSION_W];
          len_r     <= rx_meta[META_LEN_LSB +: LEN_W];
        end
      end else if (val_hs) begin
        lane <= lane + 1'b1;
      end
      if (val_hs && (value_count != '1)) value_count <= value_count + 1'b1;
      if (sum_hs) begin
        value_count <= '0;
        in_pkt      <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (rx_hs) state_nxt = SERIALIZE;
      SERIALIZE: begin
        if (val_hs && at_last_lane) begin
          if (last_r)     state_nxt = SUMMARY;
          else if (rx_hs) state_nxt = SERIALIZE;
          else            state_nxt = IDLE;
        end
      end
      SUMMARY:   if (sum_hs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // The next beat is taken in the same cycle the final lane of a non-last
  // beat is handed off, so consecutive beats stream without a bubble.
  always_comb begin
    val_valid             = 1'b0;
    pkt_rx_TREADY         = 1'b0;
    m_axis_summary_TVALID = 1'b0;
    unique case (state)
      IDLE:      pkt_rx_TREADY = 1'b1;
      SERIALIZE: begin
        val_valid     = 1'b1;
        pkt_rx_TREADY = at_last_lane && !last_r && val_ready;
      end
      SUMMARY:   m_axis_summary_TVALID = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    m_axis_summary_TDATA = '0;
    m_axis_summary_TDATA[SUM_SESSION_LSB +: SESSION_W] = session_r;
    m_axis_summary_TDATA[SUM_COUNT_LSB +: COUNT_W]     = value_count;
    m_axis_summary_TDATA[SUM_MISMATCH_BIT]             = (value_count != len_to_values(len_r));
  end

  assign slice_in = {lane_data[lane], session_r, last_r && at_last_lane};

  value_reg_slice #(
    .W      (SLICE_W),
    .ENABLE (OUT_REG)
  ) u_value_reg_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (val_valid),
    .in_ready  (val_ready),
    .in_data   (slice_in),
    .out_valid (m_axis_value_TVALID),
    .out_ready (m_axis_value_TREADY),
    .out_data  (slice_out)
  );

  assign {m_axis_value_TDATA, m_axis_value_TUSER, m_axis_value_TLAST} = slice_out;

endmodule

// File: tb/tb_pkt_value_unpacker.sv
// Scoreboard bench for pkt_value_unpacker: stimulus pushes expected values
// and summaries into queues; independent monitors pop and compare.
module tb_pkt_value_unpacker;
  localparam int DATA_W  = 512;
  localparam int META_W  = 88;
  localparam int VALUE_W = 32;
  localparam int LANES   = DATA_W / VALUE_W;
  localparam int BUS_W   = META_W + 1 + DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [BUS_W-1:0] pkt_rx_TDATA;
  logic             pkt_rx_TVALID;
  logic             pkt_rx_TREADY;
  logic [31:0]      m_axis_value_TDATA;
  logic [15:0]      m_axis_value_TUSER;
  logic             m_axis_value_TVALID;
  logic             m_axis_value_TLAST;
  logic             m_axis_value_TREADY;
  logic [32:0]      m_axis_summary_TDATA;
  logic             m_axis_summary_TVALID;
  logic             m_axis_summary_TREADY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int val_seen = 0;
  int first_val_cyc = 0;
  int last_val_cyc = 0;
  int last_sum_cyc = 0;
  int vr_mode = 0;
  logic sum_ready = 1'b1;

  logic [48:0] exp_val[$];
  logic [32:0] exp_sum[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign m_axis_summary_TREADY = sum_ready;

  pkt_value_unpacker #(
    .DATA_W  (DATA_W),
    .META_W  (META_W),
    .VALUE_W (VALUE_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pkt_rx_TDATA          (pkt_rx_TDATA),
    .pkt_rx_TVALID         (pkt_rx_TVALID),
    .pkt_rx_TREADY         (pkt_rx_TREADY),
    .m_axis_value_TDATA    (m_axis_value_TDATA),
    .m_axis_value_TUSER    (m_axis_value_TUSER),
    .m_axis_value_TVALID   (m_axis_value_TVALID),
    .m_axis_value_TLAST    (m_axis_value_TLAST),
    .m_axis_value_TREADY   (m_axis_value_TREADY),
    .m_axis_summary_TDATA  (m_axis_summary_TDATA),
    .m_axis_summary_TVALID (m_axis_summary_TVALID),
    .m_axis_summary_TREADY (m_axis_summary_TREADY)
  );

  // Value ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    m_axis_value_TREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (vr_mode)
        0:       m_axis_value_TREADY = 1'b1;
        1:       m_axis_value_TREADY = ~m_axis_value_TREADY;
        default: m_axis_value_TREADY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Value monitor: order/content against the scoreboard, plus hold-while-stalled.
  logic        held_v = 1'b0;
  logic [48:0] held;
  always @(negedge clk) begin
    logic [48:0] act;
    logic [48:0] e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      act = {m_axis_value_TDATA, m_axis_value_TUSER, m_axis_value_TLAST};
      if (held_v) begin
        checks++;
        if (!m_axis_value_TVALID || act != held) begin
          errors++;
          $display("FAIL value_hold actual valid=%0b %h required valid=1 %h", m_axis_value_TVALID, act, held);
        end
      end
      if (m_axis_value_TVALID && m_axis_value_TREADY) begin
        checks++;
        if (exp_val.size() == 0) begin
          errors++;
          $display("FAIL value_unexpected actual=%h required=none", act);
        end else begin
          e = exp_val.pop_front();
          if (act !== e)  begin
            errors++;
            $display("FAIL value actual data=%h user=%h last=%b required data=%h user=%h last=%b",
                     act[48:17], act[16:1], act[0], e[48:17], e[16:1], e[0]);
          end
        end
        if (val_seen == 0) first_val_cyc = cyc;
        last_val_cyc = cyc;
        val_seen++;
      end
      held_v = m_axis_value_TVALID && !m_axis_value_TREADY;
      held   = act;
    end
  end

  // Summary monitor.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && m_axis_summary_TVALID && m_axis_summary_TREADY) begin
      checks++;
      last_sum_cyc = cyc;
      if (exp_sum.size() == 0) begin
        errors++;
        $display("FAIL summary_unexpected actual=%h required=none", m_axis_summary_TDATA);
      end else begin
        e = exp_sum.pop_front();
        if (m_axis_summary_TDATA !== e) begin
          errors++;
          $display("FAIL summary actual mm=%b cnt=%0d sess=%h required mm=%b cnt=%0d sess=%h",
                   m_axis_summary_TDATA[32], m_axis_summary_TDATA[31:16], m_axis_summary_TDATA[15:0],
                   e[32], e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Builds one beat and records its expected values (lane i = word i).
  task automatic make_beat(input logic [15:0] beat_sess, input logic [15:0] len, input logic last,
                           input logic [15:0] pkt_sess, input bit idx_data,
                           output logic [BUS_W-1:0] bus);
    logic [DATA_W-1:0] d;
    logic [META_W-1:0] m;
    logic [31:0]       w;
    for (int i = 0; i < LANES; i++) begin
      w = idx_data ? 32'(i) : $urandom();
      d[i*32 +: 32] = w;
      exp_val.push_back({w, pkt_sess, last && (i == LANES - 1)});
    end
    for (int i = 0; i < META_W; i++) m[i] = 1'($urandom_range(0, 1));
    m[15:0]  = beat_sess;
    m[31:16] = len;
    bus = {m, last, d};
  endtask

  task automatic present_beat(input logic [BUS_W-1:0] bus, output int acc_cyc);
    logic acc;
    int   t;
    pkt_rx_TDATA  = bus;
    pkt_rx_TVALID = 1'b1;
    acc = 1'b0;
    t = 0;
    acc_cyc = -1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = pkt_rx_TREADY;
      acc_cyc = cyc;
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL rx_accept actual=not_accepted required=accepted_within_200");
    end
  endtask

  task automatic push_summary(input int nbeats, input logic [15:0] sess, input logic [15:0] len);
    int cnt;
    cnt = nbeats * LANES;
    if (cnt > 65535) cnt = 65535;
    exp_sum.push_back({1'(cnt != int'(len) / 4), 16'(cnt), sess});
  endtask

  task automatic send_packet(input int nbeats, input logic [15:0] sess, input logic [15:0] len,
                             input bit change, input int gap, input bit idx_data);
    logic [BUS_W-1:0] bus;
    int c;
    push_summary(nbeats, sess, len);
    for (int b = 0; b < nbeats; b++) begin
      make_beat((change && b > 0) ? (sess ^ 16'h5a5a) : sess, len, b == nbeats - 1, sess, idx_data, bus);
      present_beat(bus, c);
      if (gap > 0 && b < nbeats - 1) begin
        pkt_rx_TVALID = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    pkt_rx_TVALID = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_val.size() != 0 || exp_sum.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (exp_val.size() != 0 || exp_sum.size() != 0) begin
      errors++;
      $display("FAIL drain actual values=%0d summaries=%0d required 0/0", exp_val.size(), exp_sum.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BUS_W-1:0] bus;
    int t;
    int viol;
    int acc;
    int nb;
    logic [15:0] len;
    logic [32:0] held_sum;

    rst = 1'b1;
    pkt_rx_TVALID = 1'b0;
    pkt_rx_TDATA = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_ready", pkt_rx_TREADY, 1);
    chk("reset_value_valid", m_axis_value_TVALID, 0);
    chk("reset_summary_valid", m_axis_summary_TVALID, 0);
    @(posedge clk); #1;

    // Single beat, lane i = i, session 7, length 64.
    val_seen = 0;
    send_packet(1, 16'h0007, 16'd64, 0, 0, 1);
    wait_drain();
    chk("single_count", val_seen, 16);
    chk("single_span", last_val_cyc - first_val_cyc, 15);

    // Two beats back-to-back: no bubble across the beat boundary.
    val_seen = 0;
    send_packet(2, 16'(($urandom())), 16'd128, 0, 0, 0);
    wait_drain();
    chk("b2b_count", val_seen, 32);
    chk("b2b_span", last_val_cyc - first_val_cyc, 31);

    // Ready toggling every cycle.
    vr_mode = 1;
    val_seen = 0;
    send_packet(1, 16'h00a1, 16'd64, 0, 0, 0);
    wait_drain();
    chk("toggle_count", val_seen, 16);
    vr_mode = 0;

    // Length disagreeing with beats, and zero length.
    send_packet(1, 16'h0b0b, 16'd128, 0, 0, 0);
    wait_drain();
    send_packet(1, 16'h0c0c, 16'd0, 0, 0, 0);
    wait_drain();

    // Session change on beat 2 with a gap (beat 2 arrives via IDLE).
    send_packet(2, 16'h1111, 16'd128, 1, 3, 0);
    wait_drain();

    // Randomized packets.
    vr_mode = 2;
    for (int p = 0; p < 12; p++) begin
      nb  = $urandom_range(1, 3);
      len = ($urandom_range(0, 2) == 0) ? 16'($urandom()) : 16'(nb * 64);
      send_packet(nb, 16'($urandom()), len, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    end
    wait_drain();
    vr_mode = 0;

    // Reset after lane 5 of beat 0 of a two-beat packet.
    val_seen = 0;
    make_beat(16'h2222, 16'd128, 1'b0, 16'h2222, 0, bus);
    present_beat(bus, acc);
    pkt_rx_TVALID = 1'b0;
    t = 0;
    while (val_seen < 6 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("rst_mid_reached_lane5", val_seen, 6);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_val.delete();
    exp_sum.delete();
    #1 rst = 1'b0;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_axis_value_TVALID || m_axis_summary_TVALID || !pkt_rx_TREADY) viol++;
    end
    chk("rst_mid_quiet", viol, 0);
    @(posedge clk); #1;
    send_packet(1, 16'h3333, 16'd64, 0, 0, 0);
    wait_drain();

    // Summary stalled 10 cycles; next packet starts one cycle after acceptance.
    sum_ready = 1'b0;
    send_packet(1, 16'h4444, 16'd64, 0, 0, 0);
    t = 0;
    while (!m_axis_summary_TVALID && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("stall_summary_valid", m_axis_summary_TVALID, 1);
    held_sum = m_axis_summary_TDATA;
    push_summary(1, 16'h5555, 16'd64);
    make_beat(16'h5555, 16'd64, 1'b1, 16'h5555, 0, bus);
    pkt_rx_TDATA  = bus;
    pkt_rx_TVALID = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (!m_axis_summary_TVALID || m_axis_summary_TDATA != held_sum || pkt_rx_TREADY) viol++;
    end
    chk("stall_summary_hold", viol, 0);
    @(posedge clk);
    #1 sum_ready = 1'b1;
    present_beat(bus, acc);
    pkt_rx_TVALID = 1'b0;
    chk("stall_restart_latency", acc - last_sum_cyc, 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
